// File: rtl/mmio_io_hub_pkg.sv
// Register indices, KSTAT/CTRL bit positions and the KSTAT packing helper
// shared by the MMIO hub and its bench.
package mmio_io_hub_pkg;

  localparam logic [3:0] REG_SW     = 4'd0;
  localparam logic [3:0] REG_BTNLV  = 4'd1;
  localparam logic [3:0] REG_BTNEDG = 4'd2;
  localparam logic [3:0] REG_KSTAT  = 4'd3;
  localparam logic [3:0] REG_KDATA  = 4'd4;
  localparam logic [3:0] REG_LED    = 4'd5;
  localparam logic [3:0] REG_SEG    = 4'd6;
  localparam logic [3:0] REG_CTRL   = 4'd7;
  localparam logic [3:0] REG_TIMER  = 4'd8;

  localparam int KSTAT_NOT_EMPTY = 0;
  localparam int KSTAT_FULL      = 1;
  localparam int KSTAT_OVF       = 2;
  localparam int KSTAT_CNT_LSB   = 8;

  localparam int CTRL_SEG_BASE   = 0;
  localparam int CTRL_OVF_CLR    = 1;

  function automatic logic [31:0] pack_kstat(input logic       not_empty,
                                             input logic       full,
                                             input logic       ovf,
                                             input logic [7:0] cnt);
    logic [31:0] v;
    v                        = '0;
    v[KSTAT_NOT_EMPTY]       = not_empty;
    v[KSTAT_FULL]            = full;
    v[KSTAT_OVF]             = ovf;
    v[KSTAT_CNT_LSB +: 8]    = cnt;
    return v;
  endfunction

endpackage

// File: rtl/mmio_io_hub_sync_fifo.sv
// Keyboard code FIFO: power-of-two depth, count 0..DEPTH, simultaneous
// push/pop at full keeps both; a push into a full FIFO without a pop is dropped.
module mmio_io_hub_sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             pop_ok, push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];

  // A pop frees the slot the same edge, so a push at full still lands.
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign ovf_pulse = push & full & ~pop_ok;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_io_hub.sv
// Word-addressed MMIO hub for switches, buttons, keyboard FIFO, LEDs and
// seven-segment display. Define MMIO_HUB_TIMER_EN to add the cycle counter at index 8.
module mmio_io_hub
  import mmio_io_hub_pkg::*;
#(
  parameter int SW_W        = 12,
  parameter int NUM_BTN     = 4,
  parameter int KEY_W       = 5,
  parameter int KFIFO_DEPTH = 8,
  parameter int LED_W       = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               io_rd,
  input  logic               io_wr,
  input  logic [5:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [SW_W-1:0]    sw,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_code,
  output logic [LED_W-1:0]   led,
  output logic [31:0]        seg_data,
  output logic               seg_base
);

  localparam int CW = $clog2(KFIFO_DEPTH) + 1;

  logic [3:0]         idx;
  logic               rd_eff;
  logic               unused_addr;

  logic [SW_W-1:0]    sw_meta_q,  sw_meta_d;
  logic [SW_W-1:0]    sw_sync_q,  sw_sync_d;
  logic [NUM_BTN-1:0] btn_q,      btn_d;
  logic [NUM_BTN-1:0] btn_edge_q, btn_edge_d;
  logic [LED_W-1:0]   led_q,      led_d;
  logic [31:0]        seg_q,      seg_d;
  logic               seg_base_q, seg_base_d;
  logic               ovf_q,      ovf_d;

  logic               fifo_pop;
  logic [KEY_W-1:0]   fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty, fifo_ovf;

  assign idx         = addr[5:2];
  assign unused_addr = ^addr[1:0];

  // A combined read+write strobe performs the write only.
  assign rd_eff   = io_rd & ~io_wr;
  assign fifo_pop = rd_eff && (idx == REG_KDATA);

  mmio_io_hub_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (KFIFO_DEPTH)
  ) u_kfifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (key_valid),
    .pop       (fifo_pop),
    .din       (key_code),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf_pulse (fifo_ovf)
  );

  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    btn_d      = btn;
    led_d      = led_q;
    seg_d      = seg_q;
    seg_base_d = seg_base_q;
    // New edges are OR-ed after the clear so an edge in the read cycle survives.
    btn_edge_d = (btn & ~btn_q) |
                 ((rd_eff && (idx == REG_BTNEDG)) ? '0 : btn_edge_q);
    ovf_d      = fifo_ovf |
                 (ovf_q & ~(io_wr && (idx == REG_CTRL) && wdata[CTRL_OVF_CLR]));
    if (io_wr) begin
      case (idx)
        REG_LED:  led_d      = wdata[LED_W-1:0];
        REG_SEG:  seg_d      = wdata;
        REG_CTRL: seg_base_d = wdata[CTRL_SEG_BASE];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_q      <= '0;
      btn_edge_q <= '0;
      led_q      <= '0;
      seg_q      <= '0;
      seg_base_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_q      <= btn_d;
      btn_edge_q <= btn_edge_d;
      led_q      <= led_d;
      seg_q      <= seg_d;
      seg_base_q <= seg_base_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef MMIO_HUB_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (io_wr && (idx == REG_TIMER)) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`endif

  // Read data is driven every cycle; only the side effects depend on io_rd.
  always_comb begin
    rdata = '0;
    case (idx)
      REG_SW:     rdata = 32'(sw_sync_q);
      REG_BTNLV:  rdata = 32'(btn_q);
      REG_BTNEDG: rdata = 32'(btn_edge_q);
      REG_KSTAT:  rdata = pack_kstat(~fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
      REG_KDATA:  rdata = fifo_empty ? '0 : 32'(fifo_head);
      REG_LED:    rdata = 32'(led_q);
      REG_SEG:    rdata = seg_q;
      REG_CTRL:   rdata = {31'b0, seg_base_q};
`ifdef MMIO_HUB_TIMER_EN
      REG_TIMER:  rdata = timer_q;
`endif
      default:    rdata = '0;
    endcase
  end

  assign led      = led_q;
  assign seg_data = seg_q;
  assign seg_base = seg_base_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub: register map, synchroniser latency, sticky
// button edges, keyboard FIFO corner cases, reset, and the optional timer.
module tb_mmio_io_hub;
  import mmio_io_hub_pkg::*;

  localparam int SW_W  = 12;
  localparam int NBTN  = 4;
  localparam int KEY_W = 5;
  localparam int DEPTH = 8;
  localparam int LED_W = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              io_rd, io_wr;
  logic [5:0]        addr;
  logic [31:0]       wdata, rdata;
  logic [SW_W-1:0]   sw;
  logic [NBTN-1:0]   btn;
  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic [LED_W-1:0]  led;
  logic [31:0]       seg_data;
  logic              seg_base;

  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  mmio_io_hub #(
    .SW_W(SW_W), .NUM_BTN(NBTN), .KEY_W(KEY_W), .KFIFO_DEPTH(DEPTH), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rstn(rstn), .io_rd(io_rd), .io_wr(io_wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .sw(sw), .btn(btn), .key_valid(key_valid),
    .key_code(key_code), .led(led), .seg_data(seg_data), .seg_base(seg_base)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Tasks are entered and left just after a negedge; rdata is sampled #1 later.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [31:0] data);
    io_rd = 1'b1;
    addr  = {idx, 2'b00};
    #1 data = rdata;
    @(negedge clk);
    io_rd = 1'b0;
    addr  = '0;
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [31:0] val);
    io_wr = 1'b1;
    addr  = {idx, 2'b00};
    wdata = val;
    @(negedge clk);
    io_wr = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] idx, input logic [31:0] exp_v);
    logic [31:0] d;
    bus_read(idx, d);
    check(tag, d, exp_v);
  endtask

  // scoreboard: exp_q mirrors the keyboard FIFO contents
  task automatic push_key(input logic [KEY_W-1:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(32'(code));
  endtask

  task automatic read_kdata(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    read_check(tag, REG_KDATA, e);
  endtask

  task automatic push_pop(input string tag, input logic [KEY_W-1:0] code);
    logic [31:0] e;
    logic [31:0] d;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    key_valid = 1'b1;
    key_code  = code;
    bus_read(REG_KDATA, d);
    key_valid = 1'b0;
    exp_q.push_back(32'(code));
    check(tag, d, e);
  endtask

  initial begin
    rstn = 1'b0; io_rd = 1'b0; io_wr = 1'b0; addr = '0; wdata = '0;
    sw = '0; btn = '0; key_valid = 1'b0; key_code = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // reset state
    check("rst_led", 32'(led), 32'h0);
    check("rst_seg", seg_data, 32'h0);
    check("rst_base", 32'(seg_base), 32'h0);
    read_check("rst_kstat", REG_KSTAT, 32'h0);
    read_check("rst_btnedg", REG_BTNEDG, 32'h0);
    read_check("unmapped_9", 4'd9, 32'h0);
    read_check("unmapped_15", 4'd15, 32'h0);

    // LED / SEG registers
    bus_write(REG_LED, 32'hFFFF_A5A5);
    check("led_out", 32'(led), 32'h0000_A5A5);
    read_check("led_rd", REG_LED, 32'h0000_A5A5);
    bus_write(REG_SEG, 32'h1234_5678);
    check("seg_out", seg_data, 32'h1234_5678);
    read_check("seg_rd", REG_SEG, 32'h1234_5678);

    // switch synchroniser latency
    sw = 12'hABC;
    @(negedge clk);
    read_check("sw_lat1", REG_SW, 32'h0);
    read_check("sw_lat2", REG_SW, 32'h0000_0ABC);

    // button level and sticky edges
    btn = 4'b0101;
    @(negedge clk);
    read_check("btn_level", REG_BTNLV, 32'h5);
    read_check("btnedg_first", REG_BTNEDG, 32'h5);
    read_check("btnedg_cleared", REG_BTNEDG, 32'h0);
    btn = 4'b0000;
    @(negedge clk);
    btn = 4'b0100;
    read_check("btnedg_race_rd", REG_BTNEDG, 32'h0);
    read_check("btnedg_race_kept", REG_BTNEDG, 32'h4);
    read_check("btnedg_race_clr", REG_BTNEDG, 32'h0);

    // FIFO fill past full
    for (int i = 1; i <= 9; i++) push_key(KEY_W'(i));
    read_check("kstat_full_ovf", REG_KSTAT, 32'h0000_0807);
    for (int i = 0; i < DEPTH; i++) read_kdata("kdata_drain");
    read_kdata("kdata_empty");
    read_check("kstat_drained", REG_KSTAT, 32'h0000_0004);

    // CTRL: seg_base set, overflow cleared
    bus_write(REG_CTRL, 32'h3);
    check("ctrl_base", 32'(seg_base), 32'h1);
    read_check("ctrl_rd", REG_CTRL, 32'h1);
    read_check("kstat_ovf_clr", REG_KSTAT, 32'h0);

    // push + pop together while full
    for (int i = 10; i <= 17; i++) push_key(KEY_W'(i));
    read_check("kstat_full", REG_KSTAT, 32'h0000_0803);
    push_pop("kdata_full_pp", KEY_W'(18));
    read_check("kstat_full_pp", REG_KSTAT, 32'h0000_0803);

    // overflow set and W1C clear in the same cycle: set wins
    key_valid = 1'b1;
    key_code  = KEY_W'(19);
    bus_write(REG_CTRL, 32'h2);
    key_valid = 1'b0;
    read_check("kstat_ovf_setwins", REG_KSTAT, 32'h0000_0807);
    check("ctrl_base_cleared", 32'(seg_base), 32'h0);
    for (int i = 0; i < DEPTH; i++) read_kdata("kdata_drain2");
    bus_write(REG_CTRL, 32'h2);
    read_check("kstat_empty2", REG_KSTAT, 32'h0);

    // push + pop together while empty: push only
    push_pop("kdata_empty_pp", KEY_W'(20));
    read_check("kstat_empty_pp", REG_KSTAT, 32'h0000_0101);

    // read and write strobed together: no pop
    io_rd = 1'b1; io_wr = 1'b1; addr = {REG_KDATA, 2'b00}; wdata = $urandom();
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0; addr = '0; wdata = '0;
    read_check("kstat_rdwr", REG_KSTAT, 32'h0000_0101);
    read_kdata("kdata_after_rdwr");
    read_check("kstat_final", REG_KSTAT, 32'h0);

    // timer at index 8
    bus_write(REG_TIMER, $urandom());
    repeat (10) @(negedge clk);
`ifdef MMIO_HUB_TIMER_EN
    read_check("timer", REG_TIMER, 32'd10);
`else
    read_check("timer_absent", REG_TIMER, 32'd0);
`endif

    // random traffic, then a one-cycle reset
    for (int i = 0; i < 12; i++) begin
      btn       = NBTN'($urandom_range(0, 15));
      sw        = SW_W'($urandom_range(1, 4095));
      key_valid = 1'($urandom_range(0, 1));
      key_code  = KEY_W'($urandom_range(1, 31));
      bus_write(($urandom_range(0, 1) == 1) ? REG_LED : REG_SEG, $urandom());
    end
    bus_write(REG_CTRL, 32'h1);
    key_valid = 1'b0;
    btn       = '0;
    rstn      = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    check("rst2_led", 32'(led), 32'h0);
    check("rst2_seg", seg_data, 32'h0);
    check("rst2_base", 32'(seg_base), 32'h0);
    read_check("rst2_sw", REG_SW, 32'h0);
    read_check("rst2_kstat", REG_KSTAT, 32'h0);
    read_check("rst2_btnedg", REG_BTNEDG, 32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
